// File: rtl/rs_issue_unit.sv
// In-order issue front end: buffers decoded instructions and strobes each head
// into the adder or multiplier reservation station once a line is free.
module rs_issue_unit #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [15:0]   instIn,
  input  logic          instInValid,
  output logic          instInReady,
  input  logic [7:0]    BusyAdd,
  input  logic [7:0]    BusyMul,
  output logic [15:0]   instruction,
  output logic          Adderin,
  output logic          Multin,
  output logic          halted,
  output logic [AW:0]   count,
  output logic [15:0]   issuedCount
);

  typedef enum logic [1:0] {RUN, STALL, HALT} IssueState;

  IssueState     state, nextState;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          push, pop, issueAdd, issueMul, empty;
  logic [15:0]   head;
  logic [2:0]    opcode;
  logic [3:0]    zerosAdd, zerosMul, freeAdd, freeMul;
  logic          unusedBusy;

  function automatic logic [3:0] zeroCount(input logic [6:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + {3'b000, ~v[i]};
    return n;
  endfunction

  assign unusedBusy  = BusyAdd[0] ^ BusyMul[0];
  assign instInReady = (count < (AW+1)'(DEPTH));
  assign push        = instInValid && instInReady;
  assign empty       = (count == '0);
  assign head        = mem[rdPtr];
  assign opcode      = head[15:13];
  assign halted      = (state == HALT);

  // A strobe issued last cycle is not yet reflected in Busy, so it still
  // occupies one of the lines that look free.
  assign zerosAdd = zeroCount(BusyAdd[7:1]);
  assign zerosMul = zeroCount(BusyMul[7:1]);
  assign freeAdd  = (zerosAdd > {3'b000, Adderin}) ? zerosAdd - {3'b000, Adderin} : 4'd0;
  assign freeMul  = (zerosMul > {3'b000, Multin})  ? zerosMul - {3'b000, Multin}  : 4'd0;

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    issueAdd  = 1'b0;
    issueMul  = 1'b0;
    if (state != HALT) begin
      nextState = RUN;
      if (!empty) begin
        case (opcode)
          3'b000, 3'b001: begin
            if (freeAdd != 4'd0) begin
              pop      = 1'b1;
              issueAdd = 1'b1;
            end else begin
              nextState = STALL;
            end
          end
          3'b010, 3'b011: begin
            if (freeMul != 4'd0) begin
              pop      = 1'b1;
              issueMul = 1'b1;
            end else begin
              nextState = STALL;
            end
          end
          3'b111: begin
            pop       = 1'b1;
            nextState = HALT;
          end
          default: pop = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      instruction <= '0;
      Adderin     <= 1'b0;
      Multin      <= 1'b0;
      issuedCount <= '0;
    end else begin
      state   <= nextState;
      Adderin <= issueAdd;
      Multin  <= issueMul;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (issueAdd || issueMul) begin
        instruction <= head;
        issuedCount <= issuedCount + 16'd1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (push) mem[wrPtr] <= instIn;
  end

endmodule

// File: tb/tb_rs_issue_unit.sv
// Self-checking bench for rs_issue_unit against a queue-based reference model
// of the issue rules, with an optional model of the RS setting Busy bits.
module tb_rs_issue_unit;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [15:0]   instIn;
  logic          instInValid;
  logic          instInReady;
  logic [7:0]    BusyAdd, BusyMul;
  logic [15:0]   instruction;
  logic          Adderin, Multin, halted;
  logic [AW:0]   count;
  logic [15:0]   issuedCount;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mq[$];
  logic        mHalted, mAdd, mMul;
  logic [15:0] mInst, mIssued;
  logic        rsEnable, pendAdd, pendMul;

  rs_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .instIn(instIn), .instInValid(instInValid),
    .instInReady(instInReady), .BusyAdd(BusyAdd), .BusyMul(BusyMul),
    .instruction(instruction), .Adderin(Adderin), .Multin(Multin),
    .halted(halted), .count(count), .issuedCount(issuedCount)
  );

  always #5 Clock = ~Clock;

  task automatic modelReset();
    mq.delete();
    mHalted = 1'b0; mAdd = 1'b0; mMul = 1'b0;
    mInst = '0; mIssued = '0;
    pendAdd = 1'b0; pendMul = 1'b0;
  endtask

  // One clock edge of the issue rules, evaluated on the pre-edge inputs.
  task automatic modelStep();
    int freeA, freeM;
    logic [15:0] h;
    logic doPush, nA, nM;
    doPush = instInValid && (mq.size() < DEPTH);
    freeA = 7 - $countones(BusyAdd[7:1]) - int'(mAdd);
    freeM = 7 - $countones(BusyMul[7:1]) - int'(mMul);
    nA = 1'b0; nM = 1'b0;
    if (!mHalted && mq.size() > 0) begin
      h = mq[0];
      if (h[15:13] <= 3'd1) begin
        if (freeA > 0) begin nA = 1'b1; mInst = h; mIssued++; void'(mq.pop_front()); end
      end else if (h[15:13] <= 3'd3) begin
        if (freeM > 0) begin nM = 1'b1; mInst = h; mIssued++; void'(mq.pop_front()); end
      end else if (h[15:13] == 3'd7) begin
        mHalted = 1'b1; void'(mq.pop_front());
      end else begin
        void'(mq.pop_front());
      end
    end
    mAdd = nA; mMul = nM;
    if (doPush) mq.push_back(instIn);
  endtask

  function automatic logic [7:0] setLowestZero(input logic [7:0] b);
    for (int i = 1; i < 8; i++) if (!b[i]) begin b[i] = 1'b1; return b; end
    return b;
  endfunction

  // RS model: a strobe seen in one cycle marks a line busy from the next edge on.
  task automatic rsUpdate();
    if (rsEnable) begin
      if (pendAdd) BusyAdd = setLowestZero(BusyAdd);
      if (pendMul) BusyMul = setLowestZero(BusyMul);
    end
    pendAdd = Adderin;
    pendMul = Multin;
  endtask

  task automatic tick();
    @(posedge Clock);
    modelStep();
    @(negedge Clock);
    rsUpdate();
  endtask

  task automatic doReset();
    Resetn = 1'b0; instInValid = 1'b0; rsEnable = 1'b0;
    modelReset();
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic pushOne(input logic [15:0] v);
    instIn = v; instInValid = 1'b1;
    tick();
    instInValid = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; instInValid = 1'b0; instIn = '0; BusyAdd = '0; BusyMul = '0;
    rsEnable = 1'b0;
    modelReset();
    #1;
    checks++; if (count !== '0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (instruction !== 16'h0) begin failures++; $display("[TB] FAIL reset_instruction got=%h exp=0000", instruction); end
    checks++; if (Adderin !== 1'b0 || Multin !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes got=%b%b exp=00", Adderin, Multin); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (issuedCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_issued got=%0d exp=0", issuedCount); end
    checks++; if (instInReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", instInReady); end
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_single_add();
    BusyAdd = 8'h00; BusyMul = 8'h00;
    pushOne(16'h0520);
    checks++; if (Adderin !== 1'b0) begin failures++; $display("[TB] FAIL single_early got=%b exp=0", Adderin); end
    tick();
    checks++; if (Adderin !== 1'b1) begin failures++; $display("[TB] FAIL single_adderin got=%b exp=1", Adderin); end
    checks++; if (instruction !== 16'h0520) begin failures++; $display("[TB] FAIL single_inst got=%h exp=0520", instruction); end
    checks++; if (issuedCount !== 16'd1) begin failures++; $display("[TB] FAIL single_issued got=%0d exp=1", issuedCount); end
    checks++; if (Multin !== 1'b0) begin failures++; $display("[TB] FAIL single_multin got=%b exp=0", Multin); end
    tick();
    checks++; if (Adderin !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse got=%b exp=0", Adderin); end
  endtask

  task automatic test_stall8();
    int strobes;
    doReset();
    BusyAdd = 8'h00; BusyMul = 8'h00; rsEnable = 1'b1;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      instIn = {3'b000, 13'(i + 16'h40)}; instInValid = 1'b1;
      tick();
      strobes += int'(Adderin);
    end
    instInValid = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); strobes += int'(Adderin); end
    checks++; if (strobes != 7) begin failures++; $display("[TB] FAIL stall8_strobes got=%0d exp=7", strobes); end
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL stall8_count got=%0d exp=1", count); end
    checks++; if (issuedCount !== 16'd7) begin failures++; $display("[TB] FAIL stall8_issued got=%0d exp=7", issuedCount); end
    rsEnable = 1'b0;
    BusyAdd[3] = 1'b0;
    tick();
    checks++; if (Adderin !== 1'b1) begin failures++; $display("[TB] FAIL stall8_release got=%b exp=1", Adderin); end
    checks++; if (instruction !== 16'h0047) begin failures++; $display("[TB] FAIL stall8_inst got=%h exp=0047", instruction); end
    checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL stall8_drain got=%0d exp=0", count); end
  endtask

  task automatic test_stale_busy();
    doReset();
    BusyAdd = 8'hFC; BusyMul = 8'h00;
    pushOne(16'h0111);
    pushOne(16'h0222);
    checks++; if (Adderin !== 1'b1) begin failures++; $display("[TB] FAIL stale_first got=%b exp=1", Adderin); end
    tick();
    checks++; if (Adderin !== 1'b0) begin failures++; $display("[TB] FAIL stale_second got=%b exp=0", Adderin); end
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL stale_count got=%0d exp=1", count); end
  endtask

  task automatic test_in_order();
    doReset();
    BusyAdd = 8'h00; BusyMul = 8'hFE;
    pushOne(16'h4A90);
    pushOne(16'h0D10);
    tick();
    checks++; if (Adderin !== 1'b0 || Multin !== 1'b0) begin failures++; $display("[TB] FAIL order_blocked got=%b%b exp=00", Adderin, Multin); end
    checks++; if (count !== 4'd2) begin failures++; $display("[TB] FAIL order_count got=%0d exp=2", count); end
    BusyMul[5] = 1'b0;
    tick();
    checks++; if (Multin !== 1'b1 || Adderin !== 1'b0) begin failures++; $display("[TB] FAIL order_mul got=%b%b exp=01", Adderin, Multin); end
    checks++; if (instruction !== 16'h4A90) begin failures++; $display("[TB] FAIL order_mulinst got=%h exp=4a90", instruction); end
    tick();
    checks++; if (Adderin !== 1'b1 || Multin !== 1'b0) begin failures++; $display("[TB] FAIL order_add got=%b%b exp=10", Adderin, Multin); end
    checks++; if (instruction !== 16'h0D10) begin failures++; $display("[TB] FAIL order_addinst got=%h exp=0d10", instruction); end
  endtask

  task automatic test_full_wrap();
    logic [2:0] op;
    doReset();
    BusyAdd = 8'hFE; BusyMul = 8'hFE;
    for (int i = 0; i < 8; i++) pushOne({3'b000, 13'(i + 16'h100)});
    checks++; if (instInReady !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", instInReady); end
    pushOne(16'h1FFF);
    checks++; if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_ninth got=%0d exp=8", count); end
    BusyAdd = 8'hF8; rsEnable = 1'b1; pendAdd = 1'b0; pendMul = 1'b0;
    tick();
    checks++; if (count !== 4'd7 || Adderin !== 1'b1) begin failures++; $display("[TB] FAIL full_pop got=%0d/%b exp=7/1", count, Adderin); end
    pushOne(16'h0ABC);
    checks++; if (count !== 4'd7) begin failures++; $display("[TB] FAIL full_pushpop got=%0d exp=7", count); end
    rsEnable = 1'b0; BusyAdd = 8'h00; BusyMul = 8'h00;
    for (int i = 0; i < 35; i++) begin
      if (i < 20) begin
        op = 3'(2 * $urandom_range(0, 2));
        instIn = {op, 13'($urandom)}; instInValid = 1'b1;
      end else begin
        instInValid = 1'b0;
      end
      tick();
      checks++; if (Adderin !== mAdd || Multin !== mMul) begin failures++; $display("[TB] FAIL wrap_strobes cyc=%0d got=%b%b exp=%b%b", i, Adderin, Multin, mAdd, mMul); end
      checks++; if (instruction !== mInst) begin failures++; $display("[TB] FAIL wrap_inst cyc=%0d got=%h exp=%h", i, instruction, mInst); end
      checks++; if (count !== 4'(mq.size())) begin failures++; $display("[TB] FAIL wrap_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); end
    end
    instInValid = 1'b0;
  endtask

  task automatic test_halt();
    int strobes;
    doReset();
    BusyAdd = 8'h00; BusyMul = 8'h00;
    strobes = 0;
    pushOne(16'h0123); strobes += int'(Adderin);
    pushOne(16'hE000); strobes += int'(Adderin);
    pushOne(16'h0456); strobes += int'(Adderin);
    for (int i = 0; i < 4; i++) begin tick(); strobes += int'(Adderin); end
    checks++; if (strobes != 1) begin failures++; $display("[TB] FAIL halt_strobes got=%0d exp=1", strobes); end
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL halt_count got=%0d exp=1", count); end
    pushOne(16'h0789);
    pushOne(16'h4789);
    checks++; if (count !== 4'd3 || Adderin !== 1'b0 || Multin !== 1'b0) begin failures++; $display("[TB] FAIL halt_enqueue got=%0d/%b%b exp=3/00", count, Adderin, Multin); end
  endtask

  task automatic test_reset_mid();
    doReset();
    BusyAdd = 8'h00; BusyMul = 8'h00;
    pushOne(16'h0321);
    pushOne(16'h0654);
    @(posedge Clock);
    #2;
    checks++; if (Adderin !== 1'b1) begin failures++; $display("[TB] FAIL mid_prestrobe got=%b exp=1", Adderin); end
    Resetn = 1'b0;
    modelReset();
    #1;
    checks++; if (Adderin !== 1'b0 || Multin !== 1'b0) begin failures++; $display("[TB] FAIL mid_strobes got=%b%b exp=00", Adderin, Multin); end
    checks++; if (count !== '0 || instruction !== 16'h0 || issuedCount !== 16'h0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL mid_state got=%0d/%h/%0d/%b exp=0/0000/0/0", count, instruction, issuedCount, halted); end
    @(negedge Clock);
    Resetn = 1'b1;
    tick(); tick();
    checks++; if (Adderin !== 1'b0 || count !== '0) begin failures++; $display("[TB] FAIL mid_discard got=%b/%0d exp=0/0", Adderin, count); end
  endtask

  task automatic test_random();
    int r;
    doReset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 63);
      instIn = {(r == 0) ? 3'd7 : 3'(r % 7), 13'($urandom)};
      instInValid = ($urandom_range(0, 2) != 0);
      BusyAdd = 8'($urandom) | 8'($urandom);
      BusyMul = 8'($urandom) | 8'($urandom);
      tick();
      checks++; if (Adderin !== mAdd || Multin !== mMul) begin failures++; $display("[TB] FAIL rand_strobes cyc=%0d got=%b%b exp=%b%b", i, Adderin, Multin, mAdd, mMul); end
      checks++; if (instruction !== mInst) begin failures++; $display("[TB] FAIL rand_inst cyc=%0d got=%h exp=%h", i, instruction, mInst); end
      checks++; if (count !== 4'(mq.size()) || instInReady !== (mq.size() < DEPTH)) begin failures++; $display("[TB] FAIL rand_count cyc=%0d got=%0d/%b exp=%0d", i, count, instInReady, mq.size()); end
      checks++; if (issuedCount !== mIssued || halted !== mHalted) begin failures++; $display("[TB] FAIL rand_issued cyc=%0d got=%0d/%b exp=%0d/%b", i, issuedCount, halted, mIssued, mHalted); end
      if (mHalted && $urandom_range(0, 3) == 0) doReset();
    end
    instInValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_stall8();
    test_stale_busy();
    test_in_order();
    test_full_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
